// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the decode stage: tracks in-flight register writes
// after ID and raises a combinational stall when the ID instruction depends on one.
module hazard_scoreboard #(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic              fwd_en,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_dest,
    output logic              hazard,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } entry_t;

    entry_t entries [DEPTH];
    logic   raw_hit;

    // With forwarding, only a load sitting in EXE can't be bypassed in time.
    always_comb begin
        // NOTE: default first so every path assigns raw_hit and no latch is inferred.
        raw_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (entries[k].valid &&
                (entries[k].dest == src1 || (two_src && entries[k].dest == src2)) &&
                (!fwd_en || (k == 0 && entries[k].is_load))) begin
                raw_hit = 1'b1;
            end
        end
        hazard = raw_hit && !branch_taken;
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_valid[k] = entries[k].valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the entry array is tiny control state, so every field is reset, not just valid.
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
            stall_count <= '0;
        end else if (!freeze) begin
            // NOTE: non-blocking assignments make this a true shift of last cycle's values.
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
            if (hazard || branch_taken || !id_wb_en) begin
                entries[0] <= '0;
            end else begin
                entries[0] <= '{valid: 1'b1, dest: id_dest, is_load: id_mem_r_en};
            end
            if (hazard && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
